gpio_axil_slave: RTL
====================

Name: gpio_axil_slave

Overview:
AXI4-Lite responder that exposes a bank of general-purpose I/O pins as memory-mapped registers. It implements output and direction registers, a 2-FF synchronized input register, sticky rising-edge capture with write-1-to-clear, and a level interrupt. It sits behind the AXI interconnect, and the master VIP agent in the block-design bench drives it.

Parameters:
C_S_AXI_ADDR_WIDTH, 5, byte-address width; register map occupies 0x00-0x10.
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
N_GPIO, 8, number of pins (1..32); register bits above N_GPIO-1 read 0 and ignore writes.

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
gpio_in  in  N_GPIO  asynchronous pin inputs
gpio_out  out  N_GPIO  OUT register
gpio_oe  out  N_GPIO  DIR register (1 = drive)
irq  out  1  level interrupt

Behaviour:
- Register map (word index = addr[4:2]; addr[1:0] ignored):
  - 0x00 OUT, RW.
  - 0x04 DIR, RW.
  - 0x08 IN, RO (synchronized input).
  - 0x0C EDGE, W1C sticky.
  - 0x10 IRQ_EN, RW.
  - Index 5..7: unmapped.
- Reset: all registers 0. gpio_out=0, gpio_oe=0, irq=0, all READY/VALID outputs 0, BRESP/RRESP=0, RDATA=0. Sync flops are cleared.
- Write channel:
  - AWREADY and WREADY pulse high together for one cycle when AWVALID&WVALID&!BVALID&!(accept in previous cycle). No acceptance of AW without W.
  - The register updates on the cycle after the handshake. BVALID rises in the same cycle and holds until BREADY. No new write is accepted while BVALID=1.
  - RW registers honour WSTRB per byte lane.
  - EDGE clears bit i only if WDATA[i]=1 and its lane strobe is set.
  - Writes to IN or to an unmapped address have no effect. BRESP=OKAY(00) for mapped addresses (IN included), SLVERR(10) for unmapped.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID&!RVALID&!(accept in previous cycle).
  - RDATA/RRESP are registered, and RVALID rises on the next cycle. All three hold until RREADY.
  - Unmapped address: RDATA=0, RRESP=SLVERR.
- Simultaneous read and write: both channels proceed independently. A read accepted in the same cycle as a write handshake to the same register returns the pre-write value.
- Input path: gpio_in passes through a 2-FF synchronizer, then a delay flop. IN reflects the pin 2 cycles after a change.
- EDGE[i] sets when sync[i]=1 and the delayed copy is 0. If set and W1C clear hit the same bit in the same cycle, set wins.
- irq is registered: irq <= |(EDGE & IRQ_EN). It follows a change by 1 cycle.
- Reset asserted mid-transaction: outstanding B/R responses are dropped (VALID low next cycle). Registers return to reset values.

Decomposition:
- Package gpio_axil_pkg holds:
  - Register word-index constants: REG_OUT=0, REG_DIR=1, REG_IN=2, REG_EDGE=3, REG_IRQ_EN=4.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - A function that applies a 4-bit strobe mask to a 32-bit word.
- Sub-module gpio_edge_sync: per-bit 2-FF synchronizer, delay flop, and rising-edge pulse, parameterized by width.

Test Plan:
- Reset: release after 200 ns, then read 0x00-0x10 -> all 0 with RRESP=00; gpio_out=0, gpio_oe=0, irq=0.
- Full write: write 0x000000A5 to 0x00 and 0x0000000F to 0x04 -> gpio_out=0xA5 and gpio_oe=0x0F on the BVALID cycle; readback matches.
- Partial strobe: OUT=0xFF, then write 0x00000000 with WSTRB=0000 -> OUT stays 0xFF.
- Edge capture: IRQ_EN=0x01; gpio_in[0] 0->1 -> EDGE=0x01 three cycles later and irq=1 one cycle after that. Write 0x01 to 0x0C -> EDGE=0, irq=0. Time a new rising edge to coincide with the clear -> EDGE stays 1.
- Backpressure: hold BREADY=0 for 10 cycles while presenting a second write -> BVALID held, second AWREADY not asserted until after the B handshake; same check for RREADY=0 on reads.
- Unmapped and read-only: write 0x14 -> BRESP=10, no register change; read 0x1C -> RDATA=0, RRESP=10. Write to 0x08 -> BRESP=00, IN still equals the pin value.

Source files
------------

// File: rtl/gpio_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_axil_pkg
//  Description : Register indices, response codes and strobe helpers for the
//                AXI4-Lite GPIO responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_axil_pkg;

  // Word indices (byte address bits [4:2])
  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_EDGE   = 3'd3;
  localparam logic [2:0] REG_IRQ_EN = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Expand a 4-bit byte strobe into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // Merge write data into the current word on the strobed byte lanes only
  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wr,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (cur & ~m) | (wr & m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_edge_sync
//  Description : Two-flop synchronizer per pin, followed by a delay flop used
//                to detect rising edges on the synchronized value.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_dly;

  // Synchronizer chain plus one-cycle delayed copy of the synchronized value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_dly  <= '0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign sync_out = r_sync;
  assign rise     = r_sync & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/gpio_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_axil_slave
//  Description : AXI4-Lite responder exposing OUT, DIR, IN, EDGE (W1C) and
//                IRQ_EN registers for a bank of GPIO pins, with a level irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_axil_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_GPIO             = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [N_GPIO-1:0]               gpio_in,
  output logic [N_GPIO-1:0]               gpio_out,
  output logic [N_GPIO-1:0]               gpio_oe,
  output logic                            irq
);

  import gpio_axil_pkg::*;

  logic              r_awready, r_bvalid, r_arready, r_rvalid, r_irq;
  logic [1:0]        r_bresp, r_rresp;
  logic [31:0]       r_rdata;
  logic [N_GPIO-1:0] r_out, r_dir, r_edge, r_irq_en;
  logic [N_GPIO-1:0] w_in_sync, w_rise, w_edge_clr;
  logic [2:0]        w_wr_idx, w_rd_idx;
  logic              w_wr_en, w_rd_en;
  logic [31:0]       w_rd_data;
  logic [1:0]        w_rd_resp;
  logic              w_unused;

  // Address phase bits that carry no meaning for a word-wide register file
  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_wr_idx = S_AXI_AWADDR[4:2];
  assign w_rd_idx = S_AXI_ARADDR[4:2];
  assign w_wr_en  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_en  = r_arready & S_AXI_ARVALID;

  gpio_edge_sync #(.WIDTH(N_GPIO)) u_sync (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .async_in (gpio_in),
    .sync_out (w_in_sync),
    .rise     (w_rise)
  );

  // Write-one-to-clear mask for EDGE, honouring byte strobes
  always_comb begin
    w_edge_clr = '0;
    if (w_wr_en && w_wr_idx == REG_EDGE)
      w_edge_clr = N_GPIO'(S_AXI_WDATA & strb_mask(S_AXI_WSTRB));
  end

  // Write address/data acceptance and write response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wr_idx <= REG_IRQ_EN) ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file, sticky edge capture (set beats clear) and registered irq
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_out    <= '0;
      r_dir    <= '0;
      r_irq_en <= '0;
      r_edge   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        case (w_wr_idx)
          REG_OUT:    r_out    <= N_GPIO'(apply_strb(32'(r_out), S_AXI_WDATA, S_AXI_WSTRB));
          REG_DIR:    r_dir    <= N_GPIO'(apply_strb(32'(r_dir), S_AXI_WDATA, S_AXI_WSTRB));
          REG_IRQ_EN: r_irq_en <= N_GPIO'(apply_strb(32'(r_irq_en), S_AXI_WDATA, S_AXI_WSTRB));
          default:    ;
        endcase
      end
      r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      r_irq  <= |(r_edge & r_irq_en);
    end
  end

  // Read data selection from the current (pre-write) register values
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (w_rd_idx)
      REG_OUT:    w_rd_data = 32'(r_out);
      REG_DIR:    w_rd_data = 32'(r_dir);
      REG_IN:     w_rd_data = 32'(w_in_sync);
      REG_EDGE:   w_rd_data = 32'(r_edge);
      REG_IRQ_EN: w_rd_data = 32'(r_irq_en);
      default:    w_rd_resp = RESP_SLVERR;
    endcase
  end

  // Read address acceptance and registered read response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign gpio_out      = r_out;
  assign gpio_oe       = r_dir;
  assign irq           = r_irq;

endmodule
`default_nettype wire
